end_screen_overlay: RTL and testbench

- Parametrised game-end overlay stage in the vga_if pixel pipeline, placed after the game-content stages and before the output register.
- When the game ends, an end box is drawn over the incoming picture. The box grows from its centre over a fixed number of frames, then stays on screen with a border until restart.
- The fill colour is selected by the win/lose result. Pixels outside the box pass through unchanged.

---
 rtl/end_screen_pkg.sv | 17 +
 rtl/vga_if.sv | 13 +
 rtl/frame_tick.sv | 18 +
 rtl/end_screen_overlay.sv | 159 +++++++++++++++
 tb/tb_end_screen_overlay.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/end_screen_pkg.sv
// Shared types and default colours for the end-of-game overlay stage.
package end_screen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GROW = 2'd1,
    SHOW = 2'd2
  } state_e;

  localparam logic [11:0] WIN_RGB    = 12'h0f0;
  localparam logic [11:0] LOSE_RGB   = 12'hf00;
  localparam logic [11:0] BORDER_RGB = 12'hfff;

  localparam int unsigned COORD_W = 11;
  typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/vga_if.sv
// Pixel pipeline bundle: timing counters, syncs, blanking and 12-bit colour.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/frame_tick.sv
// One-cycle pulse on the rising edge of vertical blanking; shared by animated stages.
module frame_tick (
  input  logic clk,
  input  logic rst,
  input  logic vblnk,
  output logic tick_c
);

  logic vblnk_q;

  always_ff @(posedge clk) begin
    if (rst) vblnk_q <= 1'b0;
    else     vblnk_q <= vblnk;
  end

  assign tick_c = vblnk & ~vblnk_q;

endmodule

// File: rtl/end_screen_overlay.sv
// End-of-game overlay: box grows from its centre, then holds with a border until restart.
// Optional border blink is built when END_SCREEN_BLINK_EN is defined.
module end_screen_overlay
  import end_screen_pkg::*;
#(
  parameter int unsigned BOX_X0      = 300,
  parameter int unsigned BOX_Y0      = 225,
  parameter int unsigned BOX_W       = 201,
  parameter int unsigned BOX_H       = 151,
  parameter int unsigned BORDER      = 4,
  parameter int unsigned GROW_FRAMES = 16,
`ifdef END_SCREEN_BLINK_EN
  parameter int unsigned BLINK_FRAMES = 30,
`endif
  parameter logic [11:0] WIN_RGB    = end_screen_pkg::WIN_RGB,
  parameter logic [11:0] LOSE_RGB   = end_screen_pkg::LOSE_RGB,
  parameter logic [11:0] BORDER_RGB = end_screen_pkg::BORDER_RGB
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  game_over,
  input  logic  result,
  input  logic  restart,
  vga_if.in     vga_in,
  vga_if.out    vga_out,
  output logic  active
);

  localparam int unsigned DX = BOX_W / (2 * GROW_FRAMES);
  localparam int unsigned DY = BOX_H / (2 * GROW_FRAMES);
  localparam int unsigned KW = $clog2(GROW_FRAMES + 1);
  localparam logic [KW-1:0] K_FULL = KW'(GROW_FRAMES);

  state_e        state, state_next;
  logic [KW-1:0] k, k_next;
  logic          res_q, res_next;
  logic          tick;

  frame_tick u_frame_tick (
    .clk    (clk),
    .rst    (rst),
    .vblnk  (vga_in.vblnk),
    .tick_c (tick)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k     <= '0;
      res_q <= 1'b0;
    end else begin
      state <= state_next;
      k     <= k_next;
      res_q <= res_next;
    end
  end

  // next state: restart wins everywhere, grow step advances only on frame ticks
  always_comb begin
    state_next = state;
    k_next     = k;
    res_next   = res_q;
    if (restart) begin
      state_next = IDLE;
      k_next     = '0;
    end else begin
      case (state)
        IDLE: if (game_over) begin
          state_next = GROW;
          k_next     = '0;
          res_next   = result;
        end
        GROW: if (tick) begin
          k_next = k + KW'(1);
          if (k_next == K_FULL) state_next = SHOW;
        end
        SHOW: ;
        default: state_next = IDLE;
      endcase
    end
  end

  // current box edges follow k, which only moves on a frame tick
  coord_t ix, iy, x0, x1, y0, y1;
  logic   box_on, in_box, in_border, border_on;

  always_comb begin
    ix = coord_t'((GROW_FRAMES - 32'(k)) * DX);
    iy = coord_t'((GROW_FRAMES - 32'(k)) * DY);
    x0 = coord_t'(BOX_X0) + ix;
    x1 = coord_t'(BOX_X0 + BOX_W - 1) - ix;
    y0 = coord_t'(BOX_Y0) + iy;
    y1 = coord_t'(BOX_Y0 + BOX_H - 1) - iy;
    box_on    = (state != IDLE) && (k != '0);
    in_box    = (vga_in.hcount >= x0) && (vga_in.hcount <= x1) &&
                (vga_in.vcount >= y0) && (vga_in.vcount <= y1);
    in_border = ((vga_in.hcount - x0) < coord_t'(BORDER)) ||
                ((x1 - vga_in.hcount) < coord_t'(BORDER)) ||
                ((vga_in.vcount - y0) < coord_t'(BORDER)) ||
                ((y1 - vga_in.vcount) < coord_t'(BORDER));
  end

`ifdef END_SCREEN_BLINK_EN
  localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [BW-1:0] blink_cnt;

  // border toggles every BLINK_FRAMES ticks in SHOW, visible on entry
  always_ff @(posedge clk) begin
    if (rst || state == IDLE) begin
      blink_cnt <= '0;
      border_on <= 1'b1;
    end else if (state == SHOW && tick) begin
      if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt <= '0;
        border_on <= ~border_on;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end
`else
  assign border_on = 1'b1;
`endif

  // output colour selection
  logic [11:0] rgb_next;

  always_comb begin
    rgb_next = vga_in.rgb;
    if (vga_in.hblnk || vga_in.vblnk)
      rgb_next = 12'h000;
    else if (box_on && in_box)
      rgb_next = (in_border && border_on) ? BORDER_RGB : (res_q ? WIN_RGB : LOSE_RGB);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vga_out.hcount <= '0;
      vga_out.vcount <= '0;
      vga_out.hsync  <= 1'b0;
      vga_out.vsync  <= 1'b0;
      vga_out.hblnk  <= 1'b0;
      vga_out.vblnk  <= 1'b0;
      vga_out.rgb    <= '0;
      active         <= 1'b0;
    end else begin
      vga_out.hcount <= vga_in.hcount;
      vga_out.vcount <= vga_in.vcount;
      vga_out.hsync  <= vga_in.hsync;
      vga_out.vsync  <= vga_in.vsync;
      vga_out.hblnk  <= vga_in.hblnk;
      vga_out.vblnk  <= vga_in.vblnk;
      vga_out.rgb    <= rgb_next;
      active         <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_end_screen_overlay.sv
// Randomised bench for end_screen_overlay against a frame-level overlay model.
module tb_end_screen_overlay;

  localparam int GF  = 16;
  localparam int X0  = 300;
  localparam int Y0  = 225;
  localparam int W   = 201;
  localparam int H   = 151;
  localparam int BRD = 4;
  localparam int DX  = W / (2 * GF);
  localparam int DY  = H / (2 * GF);

  logic clk = 1'b0;
  logic rst, game_over, result, restart, active;

  vga_if vin();
  vga_if vout();

  end_screen_overlay dut (
    .clk       (clk),
    .rst       (rst),
    .game_over (game_over),
    .result    (result),
    .restart   (restart),
    .vga_in    (vin),
    .vga_out   (vout),
    .active    (active)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // model: overlay on/off, ticks seen since acceptance (saturating), latched result
  bit m_on    = 1'b0;
  int m_steps = 0;
  bit m_res   = 1'b0;
  bit m_vbp   = 1'b0;
  bit noise   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] ref_rgb(int h, int v, logic hb, logic vb, logic [11:0] rin);
    int ins_x, ins_y, l, r, t, b;
    if (hb || vb) return 12'h000;
    if (m_on && m_steps > 0) begin
      ins_x = (GF - m_steps) * DX;
      ins_y = (GF - m_steps) * DY;
      l = X0 + ins_x;  r = X0 + W - 1 - ins_x;
      t = Y0 + ins_y;  b = Y0 + H - 1 - ins_y;
      if (h >= l && h <= r && v >= t && v <= b) begin
        if (h - l < BRD || r - h < BRD || v - t < BRD || b - v < BRD) return 12'hfff;
        return m_res ? 12'h0f0 : 12'hf00;
      end
    end
    return rin;
  endfunction

  // one pixel clock: drive, predict, advance model, compare one cycle later
  task automatic cyc(input int h, input int v, input logic hb, input logic vb, input logic [11:0] rgb);
    logic        hs, vs, tick;
    logic [11:0] e_rgb;
    logic [10:0] e_h, e_v;
    logic        e_hs, e_vs, e_hb, e_vb;
    hs = 1'($urandom_range(0, 1));
    vs = 1'($urandom_range(0, 1));
    vin.hcount = 11'(h);
    vin.vcount = 11'(v);
    vin.hsync  = hs;
    vin.vsync  = vs;
    vin.hblnk  = hb;
    vin.vblnk  = vb;
    vin.rgb    = rgb;
    if (rst) begin
      {e_h, e_v, e_hs, e_vs, e_hb, e_vb, e_rgb} = '0;
      m_on = 1'b0; m_steps = 0; m_res = 1'b0; m_vbp = 1'b0;
    end else begin
      e_h = 11'(h); e_v = 11'(v); e_hs = hs; e_vs = vs; e_hb = hb; e_vb = vb;
      e_rgb = ref_rgb(h, v, hb, vb, rgb);
      tick  = vb && !m_vbp;
      m_vbp = vb;
      if (restart) begin
        m_on = 1'b0; m_steps = 0;
      end else if (!m_on && game_over) begin
        m_on = 1'b1; m_steps = 0; m_res = result;
      end else if (m_on && tick && m_steps < GF) begin
        m_steps++;
      end
    end
    @(posedge clk);
    #1;
    check("hcount", 32'(vout.hcount), 32'(e_h));
    check("vcount", 32'(vout.vcount), 32'(e_v));
    check("hsync",  32'(vout.hsync),  32'(e_hs));
    check("vsync",  32'(vout.vsync),  32'(e_vs));
    check("hblnk",  32'(vout.hblnk),  32'(e_hb));
    check("vblnk",  32'(vout.vblnk),  32'(e_vb));
    check("rgb",    32'(vout.rgb),    32'(e_rgb));
    check("active", 32'(active),      32'(m_on));
  endtask

  // short synthetic frame: random pixels around the box, then a vblank burst (one tick)
  task automatic frame(input int npix);
    for (int i = 0; i < npix; i++) begin
      if (noise) begin
        game_over = 1'($urandom_range(0, 1));
        result    = 1'($urandom_range(0, 1));
      end
      cyc($urandom_range(280, 520), $urandom_range(200, 390),
          1'($urandom_range(0, 9) == 0), 1'b0, 12'($urandom));
    end
    game_over = 1'b0;
    for (int i = 0; i < 3; i++)
      cyc($urandom_range(0, 800), $urandom_range(600, 627), 1'b0, 1'b1, 12'($urandom));
  endtask

  task automatic pix(input int h, input int v, input logic [11:0] rgb);
    cyc(h, v, 1'b0, 1'b0, rgb);
  endtask

  initial begin
    rst = 1'b1; game_over = 1'b0; result = 1'b0; restart = 1'b0;
    for (int i = 0; i < 3; i++) pix($urandom_range(0, 700), $urandom_range(0, 500), 12'h123);
    check("rst_rgb", 32'(vout.rgb), 32'h000);
    check("rst_active", 32'(active), 32'h0);
    rst = 1'b0;
    pix(350, 250, 12'h123);
    check("pass_after_rst", 32'(vout.rgb), 32'h123);

    // loss run
    game_over = 1'b1; result = 1'b0;
    pix(100, 100, 12'h321);
    game_over = 1'b0;
    frame(20);
    pix(400, 300, 12'h555);  check("grow1_centre", 32'(vout.rgb), 32'hf00);
    pix(300, 225, 12'h456);  check("grow1_corner", 32'(vout.rgb), 32'h456);
    noise = 1'b1;
    for (int f = 0; f < 15; f++) frame(20);
    noise = 1'b0;
    pix(300, 225, 12'h456);  check("full_corner", 32'(vout.rgb), 32'hfff);
    pix(304, 229, 12'h456);  check("full_fill", 32'(vout.rgb), 32'hf00);
    pix(500, 375, 12'h456);  check("full_far", 32'(vout.rgb), 32'hfff);
    pix(501, 300, 12'h456);  check("full_outside", 32'(vout.rgb), 32'h456);
    check("show_active", 32'(active), 32'h1);
    cyc(400, 300, 1'b1, 1'b0, 12'habc);  check("hblnk_box", 32'(vout.rgb), 32'h000);
    noise = 1'b1;
    frame(30);
    noise = 1'b0;
    pix(400, 300, 12'h111);  check("show_fill_kept", 32'(vout.rgb), 32'hf00);

    // restart mid-line
    restart = 1'b1;
    pix(400, 300, 12'h222);
    restart = 1'b0;
    pix(401, 300, 12'h789);
    check("restart_pass", 32'(vout.rgb), 32'h789);
    check("restart_active", 32'(active), 32'h0);

    // restart beats game_over in IDLE
    game_over = 1'b1; restart = 1'b1;
    pix(400, 300, 12'h333);
    game_over = 1'b0; restart = 1'b0;
    check("go_restart_idle", 32'(active), 32'h0);
    frame(10);
    pix(400, 300, 12'h444);  check("idle_pass", 32'(vout.rgb), 32'h444);

    // win run with result churn during grow/show
    game_over = 1'b1; result = 1'b1;
    pix(100, 100, 12'h000);
    game_over = 1'b0;
    noise = 1'b1;
    for (int f = 0; f < 18; f++) frame(15);
    noise = 1'b0;
    pix(400, 300, 12'h666);  check("win_fill", 32'(vout.rgb), 32'h0f0);

    // mid-operation reset
    restart = 1'b1; pix(10, 10, 12'h0); restart = 1'b0;
    game_over = 1'b1; result = 1'($urandom_range(0, 1));
    pix(10, 10, 12'h0);
    game_over = 1'b0;
    for (int f = 0; f < 5; f++) frame(10);
    rst = 1'b1; pix(400, 300, 12'h777); rst = 1'b0;
    check("midrst_active", 32'(active), 32'h0);
    pix(400, 300, 12'h777);  check("midrst_pass", 32'(vout.rgb), 32'h777);

    // random soak
    for (int i = 0; i < 1500; i++) begin
      rst       = 1'($urandom_range(0, 499) == 0);
      restart   = 1'($urandom_range(0, 199) == 0);
      game_over = 1'($urandom_range(0, 19) == 0);
      result    = 1'($urandom_range(0, 1));
      cyc($urandom_range(280, 520), $urandom_range(200, 390),
          1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 7) == 0), 12'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
